// File: rtl/vx_fpu_fma_retire.sv
// FMA retire stage: elastic result queue with lane zeroing
// and a sticky accrued-exception register feeding fcsr.fflags.
module vx_fpu_fma_retire #(
    parameter int NUM_LANES = 1,
    parameter int TAG_WIDTH = 1,
    parameter int DEPTH     = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [NUM_LANES-1:0]    mask_in,
    input  logic [TAG_WIDTH-1:0]    tag_in,
    input  logic [NUM_LANES*32-1:0] result_in,
    input  logic                    has_fflags_in,
    input  logic [4:0]              fflags_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [NUM_LANES-1:0]    mask_out,
    output logic [TAG_WIDTH-1:0]    tag_out,
    output logic [NUM_LANES*32-1:0] result_out,
    output logic                    has_fflags_out,
    output logic [4:0]              fflags_out,
    input  logic                    fflags_clr,
    output logic [4:0]              fflags_acc,
    output logic [CW-1:0]           count
);

    logic [NUM_LANES-1:0]    mask_mem_q [DEPTH];
    logic [TAG_WIDTH-1:0]    tag_mem_q  [DEPTH];
    logic [NUM_LANES*32-1:0] res_mem_q  [DEPTH];
    logic                    hf_mem_q   [DEPTH];
    logic [4:0]              ff_mem_q   [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    acc_q, acc_d;
    logic          enq, deq;

    assign ready_in  = (count_q != CW'(DEPTH));
    assign valid_out = (count_q != '0);
    assign enq       = valid_in & ready_in;
    assign deq       = valid_out & ready_out;
    assign count     = count_q;
    assign fflags_acc = acc_q;

    assign mask_out       = mask_mem_q[rd_ptr_q];
    assign tag_out        = tag_mem_q[rd_ptr_q];
    assign has_fflags_out = hf_mem_q[rd_ptr_q];
    assign fflags_out     = hf_mem_q[rd_ptr_q] ? ff_mem_q[rd_ptr_q] : 5'b0;

    // Zeroing is applied on the read side only; storage keeps raw data.
    always_comb begin
        result_out = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (mask_out[i])
                result_out[i*32 +: 32] = res_mem_q[rd_ptr_q][i*32 +: 32];
        end
    end

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Clear takes priority, then the same-cycle retire is accrued on top.
    always_comb begin
        acc_d = acc_q;
        if (fflags_clr)
            acc_d = (deq && has_fflags_out) ? fflags_out : 5'b0;
        else if (deq && has_fflags_out)
            acc_d = acc_q | fflags_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mask_mem_q[wr_ptr_q] <= mask_in;
            tag_mem_q[wr_ptr_q]  <= tag_in;
            res_mem_q[wr_ptr_q]  <= result_in;
            hf_mem_q[wr_ptr_q]   <= has_fflags_in;
            ff_mem_q[wr_ptr_q]   <= fflags_in;
        end
    end

endmodule
